// File: rtl/regfile_writeback_pkg.sv
// wb_pkg: shared types and constants for the register-file write-back stage.
//   XLEN / NUM_REGS / REG_ADDR_W : data width, register count, address width
//   REG_ZERO                     : hardwired-zero register (never written, never busy)
//   wb_entry_t                   : {rd, data} write-port payload
//   rd_onehot()                  : one-hot decode of a destination register
package wb_pkg;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 16;
  localparam int REG_ADDR_W = 4;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 4'd14;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    logic [NUM_REGS-1:0] oh;
    oh     = '0;
    oh[rd] = 1'b1;
    return oh;
  endfunction
endpackage

// File: rtl/regfile_writeback_if.sv
// regfile_writeback_if: bundle of ALU/load inputs, register-file write port,
// pending-load scoreboard and forwarding tap.
//   master : producer/consumer side (drives ALU, load and fwd_rs; reads the rest)
//   slave  : the write-back stage itself
interface regfile_writeback_if;
  import wb_pkg::*;

  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_data;
  logic                  ld_valid;
  logic                  ld_ready;
  logic [REG_ADDR_W-1:0] ld_rd;
  logic [XLEN-1:0]       ld_data;
  logic                  wb_write;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [XLEN-1:0]       wb_data;
  logic [NUM_REGS-1:0]   busy;
  logic [REG_ADDR_W-1:0] fwd_rs;
  logic                  fwd_hit;
  logic [XLEN-1:0]       fwd_data;

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, fwd_rs,
    input  ld_ready, wb_write, wb_rd, wb_data, busy, fwd_hit, fwd_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, fwd_rs,
    output ld_ready, wb_write, wb_rd, wb_data, busy, fwd_hit, fwd_data
  );
endinterface

// File: rtl/regfile_writeback_fifo.sv
// wb_fifo: in-order load-result buffer of DEPTH wb_entry_t slots.
//   clk, rst      : clock, synchronous active-high reset (empties the FIFO)
//   push_i/data   : enqueue (ignored when full)
//   pop_i         : dequeue head (ignored when empty)
//   full_o        : no free slot
//   count_o       : occupied slots
//   rd_ptr_o      : head index; head entry is ent_o[rd_ptr_o]
//   ent_o, vld_o  : raw storage and per-slot valid bits for scoreboard decode
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  wb_entry_t             push_data_i,
  input  logic                  pop_i,
  output logic                  full_o,
  output logic [CW-1:0]         count_o,
  output logic [PW-1:0]         rd_ptr_o,
  output wb_entry_t [DEPTH-1:0] ent_o,
  output logic [DEPTH-1:0]      vld_o
);
  wb_entry_t [DEPTH-1:0] mem_q;
  logic [DEPTH-1:0]      vld_q, vld_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  do_push, do_pop;

  assign full_o   = (cnt_q == CW'(DEPTH));
  assign do_push  = push_i && !full_o;
  assign do_pop   = pop_i && (cnt_q != '0);
  assign count_o  = cnt_q;
  assign rd_ptr_o = rd_ptr_q;
  assign ent_o    = mem_q;
  assign vld_o    = vld_q;

  // Push and pop never address the same slot: push needs !full, pop needs !empty.
  always_comb begin
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + 1'b1;
    end
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload needs no reset; vld_q qualifies every slot.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end
endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: owner of the single register-file write port.
// ALU results win the port; buffered load results drain when the ALU is idle.
//   clk, rst : clock, synchronous active-high reset
//   bus      : regfile_writeback_if.slave (ALU in, load handshake, wb_* write
//              port, busy scoreboard, fwd_rs/fwd_hit/fwd_data tap)
// Build option: WB_FWD_EN enables the forwarding comparator; otherwise
// fwd_hit/fwd_data are tied to zero.
module regfile_writeback
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  regfile_writeback_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic                  alu_sel, ld_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_cnt;
  logic [PW-1:0]         fifo_rd_ptr;
  wb_entry_t [DEPTH-1:0] fifo_ent;
  logic [DEPTH-1:0]      fifo_vld;
  wb_entry_t             head;

  logic                  wb_write_q, wb_write_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]       wb_data_q, wb_data_d;
  logic [NUM_REGS-1:0]   busy_c;

  assign alu_sel    = bus.alu_valid && (bus.alu_rd != REG_ZERO);
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_pop   = !alu_sel && !fifo_empty;
  // Readiness ignores a same-cycle pop, so full never accepts.
  assign bus.ld_ready = !fifo_full && !rst;
  // Zero-register loads complete the handshake but are discarded here.
  assign ld_push    = bus.ld_valid && bus.ld_ready && (bus.ld_rd != REG_ZERO);
  assign head       = fifo_ent[fifo_rd_ptr];

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (ld_push),
    .push_data_i ({bus.ld_rd, bus.ld_data}),
    .pop_i       (fifo_pop),
    .full_o      (fifo_full),
    .count_o     (fifo_cnt),
    .rd_ptr_o    (fifo_rd_ptr),
    .ent_o       (fifo_ent),
    .vld_o       (fifo_vld)
  );

  // Write-port select: ALU, else FIFO head, else hold address/data.
  always_comb begin
    wb_write_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    if (alu_sel) begin
      wb_write_d = 1'b1;
      wb_rd_d    = bus.alu_rd;
      wb_data_d  = bus.alu_data;
    end else if (fifo_pop) begin
      wb_write_d = 1'b1;
      wb_rd_d    = head.rd;
      wb_data_d  = head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_write_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_write_q <= wb_write_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  // Popped slot drops its valid bit on the same edge wb_write shows it,
  // so the busy bit clears exactly when the write becomes visible.
  always_comb begin
    busy_c = '0;
    for (int i = 0; i < DEPTH; i++)
      if (fifo_vld[i]) busy_c |= rd_onehot(fifo_ent[i].rd);
  end

  assign bus.wb_write = wb_write_q;
  assign bus.wb_rd    = wb_rd_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.busy     = busy_c;

`ifdef WB_FWD_EN
  assign bus.fwd_hit  = wb_write_q && (wb_rd_q == bus.fwd_rs);
  assign bus.fwd_data = bus.fwd_hit ? wb_data_q : '0;
`else
  logic unused_fwd_rs;
  assign unused_fwd_rs = ^bus.fwd_rs;
  assign bus.fwd_hit   = 1'b0;
  assign bus.fwd_data  = '0;
`endif
endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-back stage that owns the single write port of the 16×32 register file. It merges single-cycle ALU results with load-unit results. Load results are buffered in a small in-order FIFO and drained whenever the ALU leaves the write port idle. It also exports a per-register pending-load scoreboard, so decode can stall, and an optional forwarding tap on the write-port register.

## Interface
- DEPTH, 4: load-result FIFO entries; power of two, ≥2.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- alu_valid  in  1  ALU result present this cycle. There is no backpressure: the result is always taken.
- alu_rd  in  4  ALU destination register.
- alu_data  in  32  ALU result.
- ld_valid  in  1  load result offered.
- ld_ready  out  1  load result accepted when ld_valid && ld_ready.
- ld_rd  in  4  load destination register.
- ld_data  in  32  load result.
- wb_write  out  1  register-file write enable.
- wb_rd  out  4  register-file write address.
- wb_data  out  32  register-file write data.
- busy  out  16  bit r is set while the FIFO holds at least one entry targeting register r.
- fwd_rs  in  4  forwarding lookup register.
- fwd_hit  out  1  wb_write && wb_rd == fwd_rs.
- fwd_data  out  32  wb_data when fwd_hit is 1, else 0.

## Operation
- Register 14 is hardwired zero:
  - ALU results with rd==14 are dropped.
  - Load results with rd==14 complete the handshake but are not enqueued.
  - Register 14 never sets busy and never produces wb_write.
- Write-port selection each cycle, in priority order:
  1. An ALU result (rd≠14) is selected.
  2. Otherwise, if the FIFO is non-empty, the FIFO head is popped and selected.
  3. Otherwise nothing is selected.
- The selection is registered into wb_write/wb_rd/wb_data. If nothing is selected, wb_write=0 and wb_rd/wb_data hold their previous values.
- FIFO behaviour:
  - In order.
  - ld_ready = !full && !rst. A pop in the same cycle does not free a slot for that cycle's push.
  - A push and a pop in the same cycle are both performed.
  - Pointers are log2(DEPTH) bits and wrap; the count is log2(DEPTH)+1 bits.
- busy is combinational: the OR over valid FIFO entries of a one-hot decode of each entry's rd.
- Ordering contract: decode must not issue an ALU op whose rd has busy set. The bench asserts alu_valid && busy[alu_rd] never occurs. This block does not reorder to fix a violation.
- A load is never written to the register file in the cycle it is accepted. The FIFO has no bypass.

## Timing
- Reset state:
  - wb_write=0, wb_rd=0, wb_data=0.
  - FIFO empty, busy=0.
  - ld_ready=0 while rst is high, 1 in the first cycle after rst is released.
  - fwd_hit=0, fwd_data=0.
- ALU latency: result present in cycle N gives wb_write=1 in cycle N+1.
- Load latency:
  - A load accepted in cycle N sets busy from cycle N+1.
  - Earliest wb_write is cycle N+2; it is later by one cycle for each ALU-occupied cycle.
  - The busy bit clears in the cycle in which wb_write shows the entry, unless another entry with the same rd remains in the FIFO.
- Reset mid-operation discards all FIFO entries and any pending write. No write is issued in the cycle after rst.
- When the FIFO is full and the ALU is continuously valid, the FIFO stalls indefinitely. Starvation is acceptable by design.

## Configuration
- WB_FWD_EN defined: fwd_hit/fwd_data are driven combinationally from the wb_* output registers as specified above.
- WB_FWD_EN undefined: the ports remain present, and fwd_hit and fwd_data are tied to 0 with no comparator logic.

## Structure
- Package wb_pkg holds:
  - XLEN=32, NUM_REGS=16, REG_ADDR_W=4, REG_ZERO=4'd14.
  - A packed typedef wb_entry_t {rd, data}.
- Sub-module wb_fifo holds the parameterised DEPTH storage of wb_entry_t with push/pop/full/empty/count. It also exposes the entry array and valid bits so the busy decode can be computed in the parent.

## Test plan
- ALU only: alu_valid=1, rd=3, data=0x00001234 in cycle 0 → cycle 1 shows wb_write=1, wb_rd=3, wb_data=0x00001234. ALU idle in cycle 1 → cycle 2 shows wb_write=0.
- Register zero: an ALU result with rd=14, and a load with rd=14 accepted in the same run → wb_write stays 0 and busy stays 0.
- Priority: load rd=5 data=0xCAFEF00D accepted in cycle 0, ALU valid in cycles 1–3 with rd=1,2,3 → ALU writes appear in cycles 2–4, the load write in cycle 5, busy[5]=1 in cycles 1–4 and 0 in cycle 5.
- Full: ALU held valid, loads to rd=4..7 accepted in cycles 0–3 → ld_ready=0 from cycle 4. After the ALU drops, the four writes exit in order rd=4,5,6,7 on consecutive cycles, and ld_ready returns to 1.
- Reset mid-operation: FIFO holds 2 entries and rst is pulsed for 1 cycle → next cycle wb_write=0, busy=0, and the discarded entries are never written afterwards.
- Forwarding with WB_FWD_EN: wb_rd=7, wb_data=0xDEADBEEF, wb_write=1, fwd_rs=7 → fwd_hit=1, fwd_data=0xDEADBEEF. fwd_rs=8 → fwd_hit=0, fwd_data=0. Without WB_FWD_EN → fwd_hit=0 always.
